// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Holds the address/data widths and the request payload format.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  // Requester currently favoured by the round-robin pointer
  typedef enum logic {
    FAV_REQ0 = 1'b0,
    FAV_REQ1 = 1'b1
  } fav_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flag per architectural register.
// A set and a clear to the same register in one cycle leaves it set.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first so a same-cycle set overrides it; r0 never goes busy
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    if (set_valid) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin arbiter in front of the register-file write port.
// Winner is registered onto we3/a3/wd3 one cycle after the handshake.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [REG_DATA_W-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [REG_DATA_W-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  wb_hold,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [REG_DATA_W-1:0] wd3,
  output logic [NUM_REGS-1:0]   busy_mask
);

  fav_e      ptr_q, ptr_d;
  logic      we3_q, we3_d;
  reg_addr_t a3_q, a3_d;
  reg_data_t wd3_q, wd3_d;

  logic    gnt0, gnt1, xfer;
  wb_req_t xfer_req;

  // Grant, pointer update and next write-port contents
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    xfer     = 1'b0;
    xfer_req = '0;
    ptr_d    = ptr_q;
    we3_d    = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;

    if (!reset && !wb_hold) begin
      if (req0_valid && (!req1_valid || ptr_q == FAV_REQ0)) gnt0 = 1'b1;
      else if (req1_valid)                                   gnt1 = 1'b1;
    end

    if (gnt0) begin
      xfer_req = '{addr: req0_addr, data: req0_data};
      ptr_d    = FAV_REQ1;
    end else if (gnt1) begin
      xfer_req = '{addr: req1_addr, data: req1_data};
      ptr_d    = FAV_REQ0;
    end

    xfer = gnt0 | gnt1;
    // Writes to r0 complete the handshake but never reach the register file
    if (xfer) begin
      we3_d = (xfer_req.addr != '0);
      a3_d  = xfer_req.addr;
      wd3_d = xfer_req.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= FAV_REQ0;
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (xfer),
    .clr_addr  (xfer_req.addr),
    .busy_mask (busy_mask)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign we3        = we3_q;
  assign a3         = a3_q;
  assign wd3        = wd3_q;

endmodule
